// File: rtl/pe_job_sequencer.sv
// pe_job_sequencer: turns a vector job descriptor into a per-cycle stream of
// PE opcodes, operand RAM reads and delayed result-RAM writes.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a descriptor, job_ready high
// CLEAR  | DOTP only: one cycle of STORE_TEMP_S2 to clear the accumulator
// ISSUE  | one operand pair read and one PE opcode per cycle, len cycles
// FINAL  | DOTP only: one cycle of STORE_RESULT
// DRAIN  | NOOP while the result delay lines empty out
// DONE   | one-cycle done pulse
module pe_job_sequencer #(
    parameter int OPCODE_WIDTH    = 4,
    parameter int DRAM_DEPTH      = 256,
    parameter int DRAM_ADDR_WIDTH = $clog2(DRAM_DEPTH),
    parameter int EW_LAT          = 3,
    parameter int DP_LAT          = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [1:0]                 job_op,
    input  logic [DRAM_ADDR_WIDTH-1:0] job_a_base,
    input  logic [DRAM_ADDR_WIDTH-1:0] job_b_base,
    input  logic [DRAM_ADDR_WIDTH-1:0] job_r_base,
    input  logic [DRAM_ADDR_WIDTH:0]   job_len,
    input  logic                       abort,
    output logic [OPCODE_WIDTH-1:0]    pe_opcode,
    output logic [DRAM_ADDR_WIDTH-1:0] ram_a_read_addr,
    output logic [DRAM_ADDR_WIDTH-1:0] ram_b_read_addr,
    output logic                       ram_a_rd_en,
    output logic                       ram_b_rd_en,
    output logic [DRAM_ADDR_WIDTH-1:0] ram_result_write_addr,
    output logic                       ram_result_wr_en,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = DRAM_ADDR_WIDTH;
    localparam int LW = DRAM_ADDR_WIDTH + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DRAM_DEPTH);

    localparam logic [OPCODE_WIDTH-1:0] OP_NOOP          = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE_TEMP_S2 = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE_RESULT  = OPCODE_WIDTH'(7);
    localparam logic [1:0]              JOB_DOTP         = 2'd3;

    localparam logic [EW_LAT-1:0] EW_LAST = EW_LAT'(1) << (EW_LAT - 1);
    localparam logic [DP_LAT-1:0] DP_LAST = DP_LAT'(1) << (DP_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_FINAL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [LW-1:0]   rem_q, rem_d;
    logic [AW-1:0]   a_ptr_q, a_ptr_d;
    logic [AW-1:0]   b_ptr_q, b_ptr_d;
    logic [AW-1:0]   r_ptr_q, r_ptr_d;
    logic [AW-1:0]   r_base_q, r_base_d;
    logic [AW-1:0]   a_last_q, a_last_d;
    logic [AW-1:0]   b_last_q, b_last_d;
    logic [EW_LAT-1:0] ew_vld_q, ew_vld_d;
    logic [AW-1:0]   ew_addr_q [EW_LAT];
    logic [AW-1:0]   ew_addr_d [EW_LAT];
    logic [DP_LAT-1:0] dp_vld_q, dp_vld_d;

    logic            issue;
    logic            final_cyc;
    logic            flush;
    logic            more_pending;
    logic [LW-1:0]   len_clamped;

    assign len_clamped  = (job_len > DEPTH_L) ? DEPTH_L : job_len;
    assign more_pending = (|(ew_vld_q & ~EW_LAST)) | (|(dp_vld_q & ~DP_LAST));

    // Next-state, descriptor capture and per-state outputs.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rem_d     = rem_q;
        a_ptr_d   = a_ptr_q;
        b_ptr_d   = b_ptr_q;
        r_ptr_d   = r_ptr_q;
        r_base_d  = r_base_q;
        job_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        pe_opcode = OP_NOOP;
        issue     = 1'b0;
        final_cyc = 1'b0;
        flush     = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy      = 1'b0;
                job_ready = 1'b1;
                if (job_valid) begin
                    op_d     = job_op;
                    rem_d    = len_clamped;
                    a_ptr_d  = job_a_base;
                    b_ptr_d  = job_b_base;
                    r_ptr_d  = job_r_base;
                    r_base_d = job_r_base;
                    if (len_clamped == '0)
                        state_d = S_DONE;
                    else if (job_op == JOB_DOTP)
                        state_d = S_CLEAR;
                    else
                        state_d = S_ISSUE;
                end
            end
            S_CLEAR: begin
                pe_opcode = OP_STORE_TEMP_S2;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                issue     = 1'b1;
                pe_opcode = OPCODE_WIDTH'(op_q) + OPCODE_WIDTH'(1);
                a_ptr_d   = a_ptr_q + AW'(1);
                b_ptr_d   = b_ptr_q + AW'(1);
                r_ptr_d   = r_ptr_q + AW'(1);
                rem_d     = rem_q - LW'(1);
                if (rem_q == LW'(1))
                    state_d = (op_q == JOB_DOTP) ? S_FINAL : S_DRAIN;
            end
            S_FINAL: begin
                final_cyc = 1'b1;
                pe_opcode = OP_STORE_RESULT;
                state_d   = S_DRAIN;
            end
            S_DRAIN: begin
                if (!more_pending)
                    state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything except IDLE, where it is ignored.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            flush   = 1'b1;
        end
    end

    // Read port: live pointers while issuing, otherwise hold the last address.
    always_comb begin
        ram_a_rd_en     = issue;
        ram_b_rd_en     = issue;
        ram_a_read_addr = issue ? a_ptr_q : a_last_q;
        ram_b_read_addr = issue ? b_ptr_q : b_last_q;
        a_last_d        = ram_a_read_addr;
        b_last_d        = ram_b_read_addr;
    end

    // Result delay lines: elementwise carries (valid, addr); DOTP only valid.
    always_comb begin
        for (int i = EW_LAT - 1; i > 0; i--) begin
            ew_vld_d[i]  = ew_vld_q[i-1];
            ew_addr_d[i] = ew_addr_q[i-1];
        end
        ew_vld_d[0]  = issue && (op_q != JOB_DOTP);
        ew_addr_d[0] = r_ptr_q;

        for (int i = DP_LAT - 1; i > 0; i--)
            dp_vld_d[i] = dp_vld_q[i-1];
        dp_vld_d[0] = final_cyc;

        if (flush) begin
            ew_vld_d = '0;
            dp_vld_d = '0;
        end
    end

    assign ram_result_wr_en      = ew_vld_q[EW_LAT-1] | dp_vld_q[DP_LAT-1];
    assign ram_result_write_addr = dp_vld_q[DP_LAT-1] ? r_base_q : ew_addr_q[EW_LAT-1];

    // State, descriptor, address-hold and delay-line registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rem_q    <= '0;
            a_ptr_q  <= '0;
            b_ptr_q  <= '0;
            r_ptr_q  <= '0;
            r_base_q <= '0;
            a_last_q <= '0;
            b_last_q <= '0;
            ew_vld_q <= '0;
            dp_vld_q <= '0;
            for (int i = 0; i < EW_LAT; i++)
                ew_addr_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            a_ptr_q  <= a_ptr_d;
            b_ptr_q  <= b_ptr_d;
            r_ptr_q  <= r_ptr_d;
            r_base_q <= r_base_d;
            a_last_q <= a_last_d;
            b_last_q <= b_last_d;
            ew_vld_q <= ew_vld_d;
            dp_vld_q <= dp_vld_d;
            for (int i = 0; i < EW_LAT; i++)
                ew_addr_q[i] <= ew_addr_d[i];
        end
    end

endmodule
